// File: rtl/ysyx_22040931_lsu.sv
// Multi-cycle load/store unit between EX and WB: aligns stores onto byte lanes, extends loads,
// flags misaligned/illegal accesses and stalls EX via in_ready while a bus transaction is open.
module ysyx_22040931_lsu #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int PC_W   = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_ena_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        memop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              w_ena_i,
    input  logic [REG_W-1:0]  w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wr,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W/8-1:0] req_wmask,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              out_valid,
    output logic              w_ena,
    output logic [REG_W-1:0]  w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic [PC_W-1:0]   pc_o,
    output logic              misalign_o
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e              state_q, state_d;
    logic                req_wr_q, req_wr_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [LANES-1:0]    req_wmask_q, req_wmask_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [OFS_W-1:0]    ofs_q, ofs_d;
    logic                pend_wena_q, pend_wena_d;
    logic [REG_W-1:0]    pend_waddr_q, pend_waddr_d;
    logic [PC_W-1:0]     pend_pc_q, pend_pc_d;
    logic                out_valid_q, out_valid_d;
    logic                w_ena_q, w_ena_d;
    logic [REG_W-1:0]    w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [PC_W-1:0]     pc_o_q, pc_o_d;
    logic                misalign_q, misalign_d;

    function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] sz);
        int unsigned nbits;
        nbits = 8 << sz;
        if (nbits >= DATA_W) data_mask = '1;
        else                 data_mask = (DATA_W'(1) << nbits) - DATA_W'(1);
    endfunction

    function automatic logic [LANES-1:0] byte_mask(input logic [1:0] sz);
        int unsigned nbytes;
        nbytes = 1 << sz;
        if (nbytes >= LANES) byte_mask = '1;
        else                 byte_mask = (LANES'(1) << nbytes) - LANES'(1);
    endfunction

    logic [1:0]          acc_size;
    logic [2:0]          align_mask;
    logic                acc_bad;
    logic [OFS_W-1:0]    acc_ofs;
    logic [DATA_W-1:0]   ld_shift;
    logic [DATA_W-1:0]   ld_mask;
    logic                ld_sign;
    logic [DATA_W-1:0]   ld_val;

    always_comb begin
        acc_size   = memop_i[1:0];
        align_mask = (3'd1 << acc_size) - 3'd1;
        acc_bad    = (|(addr_i[2:0] & align_mask)) || (acc_size == 2'd3 && DATA_W == 32);
        acc_ofs    = addr_i[OFS_W-1:0];

        // Load extraction works from the size/offset captured at accept, not the live inputs.
        ld_shift = rsp_rdata >> {ofs_q, 3'b000};
        ld_mask  = data_mask(size_q);
        case (size_q)
            2'd0:    ld_sign = ld_shift[7];
            2'd1:    ld_sign = ld_shift[15];
            2'd2:    ld_sign = ld_shift[31];
            default: ld_sign = 1'b0;
        endcase
        ld_sign = ld_sign & ~uns_q;
        ld_val  = (ld_shift & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

    always_comb begin
        state_d      = state_q;
        req_wr_d     = req_wr_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wmask_d  = req_wmask_q;
        size_d       = size_q;
        uns_d        = uns_q;
        ofs_d        = ofs_q;
        pend_wena_d  = pend_wena_q;
        pend_waddr_d = pend_waddr_q;
        pend_pc_d    = pend_pc_q;
        out_valid_d  = 1'b0;
        w_ena_d      = w_ena_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        pc_o_d       = pc_o_q;
        misalign_d   = misalign_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!mem_ena_i || acc_bad) begin
                        out_valid_d = 1'b1;
                        w_ena_d     = mem_ena_i ? 1'b0 : w_ena_i;
                        w_data_d    = mem_ena_i ? '0 : w_data_i;
                        misalign_d  = mem_ena_i;
                        w_addr_d    = w_addr_i;
                        pc_o_d      = pc_i;
                    end else begin
                        state_d      = S_REQ;
                        req_wr_d     = mem_wr_i;
                        req_addr_d   = {addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        req_wdata_d  = mem_wr_i ? ((wdata_i & data_mask(acc_size)) << {acc_ofs, 3'b000}) : '0;
                        req_wmask_d  = mem_wr_i ? (byte_mask(acc_size) << acc_ofs) : '0;
                        size_d       = acc_size;
                        uns_d        = memop_i[2];
                        ofs_d        = acc_ofs;
                        pend_wena_d  = w_ena_i;
                        pend_waddr_d = w_addr_i;
                        pend_pc_d    = pc_i;
                    end
                end
            end
            S_REQ: begin
                if (req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    w_ena_d     = req_wr_q ? 1'b0 : pend_wena_q;
                    w_data_d    = req_wr_q ? '0 : ld_val;
                    misalign_d  = 1'b0;
                    w_addr_d    = pend_waddr_q;
                    pc_o_d      = pend_pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_wr_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wmask_q  <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            ofs_q        <= '0;
            pend_wena_q  <= 1'b0;
            pend_waddr_q <= '0;
            pend_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            w_ena_q      <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            pc_o_q       <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_wr_q     <= req_wr_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wmask_q  <= req_wmask_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            ofs_q        <= ofs_d;
            pend_wena_q  <= pend_wena_d;
            pend_waddr_q <= pend_waddr_d;
            pend_pc_q    <= pend_pc_d;
            out_valid_q  <= out_valid_d;
            w_ena_q      <= w_ena_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            pc_o_q       <= pc_o_d;
            misalign_q   <= misalign_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign req_valid  = (state_q == S_REQ);
    assign req_wr     = req_wr_q;
    assign req_addr   = req_addr_q;
    assign req_wdata  = req_wdata_q;
    assign req_wmask  = req_wmask_q;
    assign out_valid  = out_valid_q;
    assign w_ena      = w_ena_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign pc_o       = pc_o_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_ysyx_22040931_lsu.sv
// Directed self-checking bench for the load/store unit (DATA_W = 64).
module tb_ysyx_22040931_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mem_ena_i;
    logic        mem_wr_i;
    logic [2:0]  memop_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        w_ena_i;
    logic [4:0]  w_addr_i;
    logic [63:0] w_data_i;
    logic [63:0] pc_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        out_valid;
    logic        w_ena;
    logic [4:0]  w_addr;
    logic [63:0] w_data;
    logic [63:0] pc_o;
    logic        misalign_o;

    int tests = 0;
    int fails = 0;

    ysyx_22040931_lsu #(.DATA_W(64), .ADDR_W(64), .PC_W(64), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_ena_i(mem_ena_i), .mem_wr_i(mem_wr_i), .memop_i(memop_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .w_ena_i(w_ena_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .pc_i(pc_i), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .out_valid(out_valid),
        .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data), .pc_o(pc_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_ena_i = 0; mem_wr_i = 0; memop_i = 0; addr_i = 0; wdata_i = 0;
        w_ena_i = 0; w_addr_i = 0; w_data_i = 0; pc_i = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
    endtask

    // Runs one aligned load through accept/REQ/WAIT with immediate bus handshakes.
    task automatic do_load(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] rdata,
                           output logic ov, output logic [63:0] data);
        in_valid = 1; mem_ena_i = 1; mem_wr_i = 0; memop_i = op; addr_i = addr;
        w_ena_i = 1; w_addr_i = 5'd9; pc_i = 64'h200; req_ready = 1;
        step();
        in_valid = 0;
        step();
        rsp_valid = 1; rsp_rdata = rdata;
        step();
        ov = out_valid; data = w_data;
        rsp_valid = 0; req_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if ({misalign_o, w_ena} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {misalign_o, w_ena}); end
        tests++; if ({w_data, pc_o, req_addr, req_wdata} !== '0) begin fails++; $display("FAIL reset_data got w_data=%h pc=%h exp 0", w_data, pc_o); end
        tests++; if (req_wmask !== 8'h00) begin fails++; $display("FAIL reset_wmask got %h exp 00", req_wmask); end
    endtask

    task automatic test_load_byte();
        in_valid = 1; mem_ena_i = 1; mem_wr_i = 0; memop_i = 3'd0; addr_i = 64'h8000_0003;
        w_ena_i = 1; w_addr_i = 5'd5; pc_i = 64'h100; req_ready = 1;
        step();
        in_valid = 0; addr_i = 64'hDEAD_BEEF;
        tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL lb_req_valid got %b exp 1", req_valid); end
        tests++; if (req_addr !== 64'h8000_0000) begin fails++; $display("FAIL lb_req_addr got %h exp 80000000", req_addr); end
        tests++; if ({req_wr, req_wmask} !== 9'h000) begin fails++; $display("FAIL lb_req_rd got wr=%b mask=%h exp 0/00", req_wr, req_wmask); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL lb_in_ready_req got %b exp 0", in_ready); end
        rsp_valid = 1; rsp_rdata = 64'h0000_0000_8000_0000;
        step();
        tests++; if ({out_valid, req_valid, in_ready} !== 3'b000) begin fails++; $display("FAIL lb_wait_state got %b exp 000", {out_valid, req_valid, in_ready}); end
        step();
        rsp_valid = 0; req_ready = 0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lb_out_valid got %b exp 1", out_valid); end
        tests++; if (w_data !== 64'hFFFF_FFFF_FFFF_FF80) begin fails++; $display("FAIL lb_w_data got %h exp ffffffffffffff80", w_data); end
        tests++; if ({w_ena, w_addr, misalign_o} !== {1'b1, 5'd5, 1'b0}) begin fails++; $display("FAIL lb_wb got ena=%b addr=%0d mis=%b exp 1/5/0", w_ena, w_addr, misalign_o); end
        tests++; if (pc_o !== 64'h100) begin fails++; $display("FAIL lb_pc got %h exp 100", pc_o); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lb_pulse got %b exp 0", out_valid); end
        tests++; if (w_data !== 64'hFFFF_FFFF_FFFF_FF80) begin fails++; $display("FAIL lb_hold got %h exp ffffffffffffff80", w_data); end
    endtask

    task automatic test_load_ext();
        logic ov;
        logic [63:0] d;
        do_load(3'd6, 64'h8000_0004, 64'h8765_4321_DEAD_BEEF, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'h0000_0000_8765_4321}) begin fails++; $display("FAIL lwu got ov=%b %h exp 1 0000000087654321", ov, d); end
        do_load(3'd2, 64'h8000_0004, 64'h8765_4321_DEAD_BEEF, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'hFFFF_FFFF_8765_4321}) begin fails++; $display("FAIL lw got ov=%b %h exp 1 ffffffff87654321", ov, d); end
        do_load(3'd5, 64'h8000_0002, 64'h0000_0000_F00D_0000, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'h0000_0000_0000_F00D}) begin fails++; $display("FAIL lhu got ov=%b %h exp 1 000000000000f00d", ov, d); end
        do_load(3'd1, 64'h8000_0002, 64'h0000_0000_F00D_0000, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'hFFFF_FFFF_FFFF_F00D}) begin fails++; $display("FAIL lh got ov=%b %h exp 1 fffffffffffff00d", ov, d); end
        do_load(3'd7, 64'h8000_0008, 64'h8000_0000_0000_0001, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'h8000_0000_0000_0001}) begin fails++; $display("FAIL ld got ov=%b %h exp 1 8000000000000001", ov, d); end
        do_load(3'd4, 64'h8000_0007, 64'h7F00_0000_0000_0000, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'h0000_0000_0000_007F}) begin fails++; $display("FAIL lbu got ov=%b %h exp 1 000000000000007f", ov, d); end
    endtask

    task automatic test_store_half();
        in_valid = 1; mem_ena_i = 1; mem_wr_i = 1; memop_i = 3'd1; addr_i = 64'h8000_0006;
        wdata_i = 64'h1234_ABCD; w_ena_i = 1; w_addr_i = 5'd7; pc_i = 64'h300; req_ready = 1;
        step();
        in_valid = 0;
        tests++; if (req_wdata !== 64'hABCD_0000_0000_0000) begin fails++; $display("FAIL sh_wdata got %h exp abcd000000000000", req_wdata); end
        tests++; if (req_wmask !== 8'hC0) begin fails++; $display("FAIL sh_wmask got %h exp c0", req_wmask); end
        tests++; if ({req_valid, req_wr, req_addr} !== {2'b11, 64'h8000_0000}) begin fails++; $display("FAIL sh_req got v=%b wr=%b a=%h exp 1/1/80000000", req_valid, req_wr, req_addr); end
        step();
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sh_no_ack got %b exp 0", out_valid); end
        rsp_valid = 1;
        step();
        rsp_valid = 0; req_ready = 0;
        tests++; if ({out_valid, w_ena, misalign_o} !== 3'b100) begin fails++; $display("FAIL sh_retire got %b exp 100", {out_valid, w_ena, misalign_o}); end
        tests++; if ({w_addr, pc_o} !== {5'd7, 64'h300}) begin fails++; $display("FAIL sh_wb_tag got addr=%0d pc=%h exp 7/300", w_addr, pc_o); end
    endtask

    task automatic test_misalign();
        in_valid = 1; mem_ena_i = 1; mem_wr_i = 0; memop_i = 3'd2; addr_i = 64'h8000_0002;
        w_ena_i = 1; w_addr_i = 5'd3; pc_i = 64'h400; req_ready = 1;
        step();
        in_valid = 0;
        tests++; if ({out_valid, misalign_o, w_ena, req_valid, in_ready} !== 5'b11001) begin fails++; $display("FAIL mis_w got %b exp 11001", {out_valid, misalign_o, w_ena, req_valid, in_ready}); end
        tests++; if (w_data !== 64'h0) begin fails++; $display("FAIL mis_w_data got %h exp 0", w_data); end
        step();
        tests++; if ({out_valid, misalign_o, req_valid} !== 3'b010) begin fails++; $display("FAIL mis_after got %b exp 010", {out_valid, misalign_o, req_valid}); end
        in_valid = 1; mem_wr_i = 1; memop_i = 3'd3; addr_i = 64'h8000_0004;
        step();
        in_valid = 0; req_ready = 0;
        tests++; if ({out_valid, misalign_o, w_ena, req_valid} !== 4'b1100) begin fails++; $display("FAIL mis_sd got %b exp 1100", {out_valid, misalign_o, w_ena, req_valid}); end
        step();
    endtask

    task automatic test_backpressure();
        int pulses;
        pulses = 0;
        in_valid = 1; mem_ena_i = 1; mem_wr_i = 0; memop_i = 3'd6; addr_i = 64'h8000_0004;
        w_ena_i = 1; w_addr_i = 5'd11; pc_i = 64'h500; req_ready = 0;
        step();
        in_valid = 0; addr_i = 64'h0; memop_i = 3'd0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({req_valid, in_ready, out_valid, req_wr, req_addr, req_wmask} !== {4'b1000, 64'h8000_0000, 8'h00}) begin
                fails++; $display("FAIL bp_hold_%0d got v=%b rdy=%b ov=%b a=%h exp 1/0/0/80000000", i, req_valid, in_ready, out_valid, req_addr);
            end
            step();
        end
        req_ready = 1;
        step();
        req_ready = 0;
        for (int i = 0; i < 2; i++) begin
            tests++; if ({req_valid, in_ready, out_valid} !== 3'b000) begin fails++; $display("FAIL bp_wait_%0d got %b exp 000", i, {req_valid, in_ready, out_valid}); end
            step();
        end
        rsp_valid = 1; rsp_rdata = 64'h8765_4321_DEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            rsp_valid = 0;
            if (out_valid) pulses++;
            if (i == 0) begin
                tests++; if (w_data !== 64'h0000_0000_8765_4321) begin fails++; $display("FAIL bp_w_data got %h exp 0000000087654321", w_data); end
            end
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL bp_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_back_to_back();
        logic ov;
        logic [63:0] d;
        in_valid = 1; mem_ena_i = 0; w_ena_i = 1; w_addr_i = 5'd3; w_data_i = 64'h55; pc_i = 64'h600;
        step();
        tests++; if ({out_valid, w_ena, misalign_o, in_ready} !== 4'b1101) begin fails++; $display("FAIL nm_flags got %b exp 1101", {out_valid, w_ena, misalign_o, in_ready}); end
        tests++; if ({w_data, w_addr, pc_o} !== {64'h55, 5'd3, 64'h600}) begin fails++; $display("FAIL nm_data got d=%h a=%0d pc=%h exp 55/3/600", w_data, w_addr, pc_o); end
        for (int i = 0; i < 4; i++) begin
            w_data_i = 64'h60 + 64'(i); w_ena_i = i[0]; pc_i = 64'h604 + 64'(4 * i);
            step();
            tests++;
            if ({out_valid, w_ena, w_data} !== {1'b1, i[0], 64'h60 + 64'(i)}) begin
                fails++; $display("FAIL b2b_%0d got ov=%b ena=%b d=%h exp 1/%b/%h", i, out_valid, w_ena, w_data, i[0], 64'h60 + 64'(i));
            end
        end
        // A load accepted while the previous result is still pulsing.
        mem_ena_i = 1; memop_i = 3'd0; addr_i = 64'h8000_0001; w_ena_i = 1; w_addr_i = 5'd4; req_ready = 1;
        step();
        in_valid = 0;
        tests++; if ({req_valid, out_valid, in_ready} !== 3'b100) begin fails++; $display("FAIL b2b_mem_accept got %b exp 100", {req_valid, out_valid, in_ready}); end
        step();
        rsp_valid = 1; rsp_rdata = 64'h0000_0000_0000_2A00;
        step();
        rsp_valid = 0; req_ready = 0;
        tests++; if ({out_valid, w_data, w_addr} !== {1'b1, 64'h2A, 5'd4}) begin fails++; $display("FAIL b2b_mem_ret got ov=%b d=%h a=%0d exp 1/2a/4", out_valid, w_data, w_addr); end
        do_load(3'd0, 64'h8000_0000, 64'hFF, ov, d);
        tests++; if ({ov, d} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin fails++; $display("FAIL lb_ffff got ov=%b %h exp 1 ffffffffffffffff", ov, d); end
    endtask

    task automatic test_rst_wait();
        in_valid = 1; mem_ena_i = 1; mem_wr_i = 0; memop_i = 3'd3; addr_i = 64'h8000_0010;
        w_ena_i = 1; w_addr_i = 5'd12; pc_i = 64'h700; req_ready = 1;
        step();
        in_valid = 0;
        step();
        req_ready = 0;
        tests++; if ({in_ready, req_valid} !== 2'b00) begin fails++; $display("FAIL rw_in_wait got %b exp 00", {in_ready, req_valid}); end
        rst = 1;
        step();
        rst = 0;
        tests++; if ({in_ready, req_valid, out_valid, w_ena} !== 4'b1000) begin fails++; $display("FAIL rw_after_rst got %b exp 1000", {in_ready, req_valid, out_valid, w_ena}); end
        tests++; if ({w_data, pc_o} !== '0) begin fails++; $display("FAIL rw_data_clr got d=%h pc=%h exp 0/0", w_data, pc_o); end
        rsp_valid = 1; rsp_rdata = 64'h1234;
        step();
        rsp_valid = 0;
        tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL rw_stray_rsp got %b exp 01", {out_valid, in_ready}); end
        step();
        tests++; if ({out_valid, in_ready, w_data} !== {2'b01, 64'h0}) begin fails++; $display("FAIL rw_stray_late got ov=%b rdy=%b d=%h exp 0/1/0", out_valid, in_ready, w_data); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_ext();
        test_store_half();
        test_misalign();
        test_backpressure();
        test_back_to_back();
        test_rst_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
